nios_mult_arbiter: RTL and testbench
====================================

Name: nios_mult_arbiter

Overview:
- Shares one pipelined 32x32 multiplier cell (low-32-bit product, fixed latency) between NUM_REQ requesters, e.g. CPU custom-instruction port and a DMA/filter engine.
- Round-robin arbitration with valid/ready request handshake; registers operands into the cell.
- Tracks in-flight operations with a tag pipeline and steers each result back to its originator.
- Sits between the requesting masters and the multiplier cell instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- LATENCY, 1, cycles from operands presented on mul_src1/mul_src2 to a valid mul_result (cell-internal register count).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_src1  in  32*NUM_REQ  operand A, requester i at [32i+31:32i].
- req_src2  in  32*NUM_REQ  operand B, same packing.
- rsp_valid  out  NUM_REQ  one-cycle result strobe to the originating requester.
- rsp_result  out  32  result data, shared by all requesters, qualified by rsp_valid.
- mul_src1  out  32  operand A to the multiplier cell.
- mul_src2  out  32  operand B to the multiplier cell.
- mul_result  in  32  product from the multiplier cell.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, mul_src1=mul_src2=0, busy=0, rr_ptr=0. All tag-pipeline valids are cleared.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready = one-hot of the winner, or 0 if no request is pending.
  - req_ready is 0 while reset is high.
- Accept: a transfer occurs in cycle k when req_valid[i] & req_ready[i].
  - On the edge that ends cycle k: mul_src1/mul_src2 <= that requester's operands.
  - On the same edge: rr_ptr <= (i+1) mod NUM_REQ, and the tag stage-0 entry <= {valid=1, id=i}.
  - With no accept: rr_ptr holds, mul_src holds its last value (no toggling), and stage-0 valid <= 0.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}; shifts every cycle, with no stall.
  - Stage LATENCY is aligned with mul_result being valid (cycle k+1+LATENCY).
- Response:
  - On the edge ending cycle k+1+LATENCY: rsp_result <= mul_result and rsp_valid <= one-hot(id).
  - Otherwise rsp_valid <= 0 and rsp_result holds.
  - Total latency from accept to rsp_valid is LATENCY+2 cycles (3 at default).
  - There is no response backpressure: requesters must sink rsp_valid.
- Throughput: one accept per cycle; back-to-back accepts from the same or different requesters are legal.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,..,N-1,0,… with no starvation.
- Arithmetic: the result is the low 32 bits of the unsigned product, which equals the low 32 bits of the signed product. Overflow wraps silently.
- busy: OR of all tag-pipeline valids and any pending rsp_valid.
- Request rules:
  - A requester may drop req_valid without an accept.
  - Operands must be stable while req_valid=1 and req_ready=0.
- Reset mid-operation: all in-flight operations are discarded and no rsp_valid is generated for them. The first grant after reset starts at requester 0.

Test Plan:
- Single op: req0 sends 0x00001234 * 0x00005678 in cycle 0 -> req_ready[0]=1 in cycle 0; rsp_valid=2'b01 with rsp_result=0x06260060 in cycle 3; busy high in cycles 1–3.
- Wrap: req1 sends 0xFFFFFFFF*0xFFFFFFFF, then 0x00010000*0x00010000 back-to-back -> rsp_valid=2'b10 in consecutive cycles, with results 0x00000001 then 0x00000000.
- Fairness: both requesters valid for 6 cycles, operands (i+1)*(cycle+1) -> grant order 0,1,0,1,0,1; six responses in cycles 3..8, each steered to its originator with the correct product.
- Pointer hold: only req1 valid for 3 cycles, then both valid -> the next grant goes to req0 (rr_ptr=0 after req1's last grant); mul_src holds its value during idle cycles.
- Reset mid-flight: accepts in cycles 0 and 1, reset high in cycle 2 -> no rsp_valid in cycles 3–4; all outputs are 0 in cycle 3; the first post-reset grant goes to req0.
- Idle: no req_valid for 10 cycles -> req_ready=0, rsp_valid=0 and busy=0 throughout.

Source files
------------

// File: rtl/nios_mult_arbiter.sv
// nios_mult_arbiter: round-robin front end for one shared pipelined 32x32
// multiplier cell. It grants one requester per cycle and registers that
// requester's operands into the cell. A {valid, id} tag pipeline follows each
// operation through the cell, so the product is routed back to the requester
// that issued it.
module nios_mult_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_src1,
    input  logic [32*NUM_REQ-1:0]   req_src2,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_result,
    output logic [31:0]             mul_src1,
    output logic [31:0]             mul_src2,
    input  logic [31:0]             mul_result,
    output logic                    busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

    logic [IDW-1:0]              rr_ptr;
    logic [NUM_REQ-1:0]          grant;
    logic [IDW-1:0]              grant_id;
    logic [IDW-1:0]              next_ptr;
    logic                        accept;
    logic [31:0]                 sel_src1;
    logic [31:0]                 sel_src2;
    logic [LATENCY:0]            vld_pipe;
    logic [LATENCY:0][IDW-1:0]   id_pipe;
    logic [NUM_REQ-1:0]          rsp_dec;

    // Round-robin search: scan from rr_ptr and wrap; the first valid requester wins.
    always_comb begin
        logic         found;
        logic [IDW:0] sum;
        logic [IDW-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= NREQ_W)
                sum = sum - NREQ_W;
            idx = sum[IDW-1:0];
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

    // Nothing is granted while reset is held.
    assign req_ready = reset ? '0 : grant;
    assign accept    = |req_ready;

    // Pointer advances to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        logic [IDW:0] nxt;
        nxt = {1'b0, grant_id} + (IDW+1)'(1);
        if (nxt >= NREQ_W)
            nxt = '0;
        next_ptr = nxt[IDW-1:0];
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                sel_src1 = req_src1[32*j +: 32];
                sel_src2 = req_src2[32*j +: 32];
            end
        end
    end

    // Decode the id in the last tag stage into a per-requester strobe.
    always_comb begin
        rsp_dec = '0;
        for (int j = 0; j < NUM_REQ; j++)
            rsp_dec[j] = (id_pipe[LATENCY] == IDW'(j));
    end

    // Operand registers and round-robin pointer. Both hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            mul_src1 <= '0;
            mul_src2 <= '0;
        end else if (accept) begin
            rr_ptr   <= next_ptr;
            mul_src1 <= sel_src1;
            mul_src2 <= sel_src2;
        end
    end

    // Tag pipeline. It never stalls; stage LATENCY lines up with a valid mul_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= accept;
            id_pipe[0]  <= grant_id;
            for (int s = 1; s <= LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    // Capture the product and strobe the requester that issued it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= vld_pipe[LATENCY] ? rsp_dec : '0;
            if (vld_pipe[LATENCY])
                rsp_result <= mul_result;
        end
    end

    assign busy = (|vld_pipe) | (|rsp_valid);

endmodule

// File: tb/tb_nios_mult_arbiter.sv
// Directed bench for nios_mult_arbiter with NUM_REQ=2 and LATENCY=1. A
// behavioural one-register multiplier stands in for the cell. Inputs change
// 1ns after each rising edge, and outputs are sampled on the falling edge.
module tb_nios_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_src1 = '0;
    logic [63:0] req_src2 = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_result;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [31:0] mul_result = '0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    nios_mult_arbiter #(.NUM_REQ(2), .LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .mul_src1(mul_src1), .mul_src2(mul_src2),
        .mul_result(mul_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier cell model: one register stage, low 32 bits of the product.
    always @(posedge clk) mul_result <= mul_src1 * mul_src2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges and leaves the bench at the start of cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        tick();
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
        vectors++;
        if (rsp_valid !== 2'b00 || rsp_result !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp got v=%b r=%h busy=%b exp 00/0/0", rsp_valid, rsp_result, busy);
        end
        vectors++;
        if (mul_src1 !== 32'h0 || mul_src2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mulsrc got %h %h exp 0 0", mul_src1, mul_src2);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01;
        req_src1[31:0] = 32'h0000_1234;
        req_src2[31:0] = 32'h0000_5678;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_c0 ready=%b busy=%b exp 01/0", req_ready, busy);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || mul_src1 !== 32'h1234 || mul_src2 !== 32'h5678 || rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_c1 busy=%b src=%h,%h rsp=%b exp 1/1234,5678/00", busy, mul_src1, mul_src2, rsp_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_c2 busy=%b rsp=%b exp 1/00", busy, rsp_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'h0626_0060 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_c3 rsp=%b res=%h busy=%b exp 01/06260060/1", rsp_valid, rsp_result, busy);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'h0626_0060) begin
            miscompares++;
            $display("FAIL single_c4 rsp=%b busy=%b res=%h exp 00/0/06260060", rsp_valid, busy, rsp_result);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 2'b10;
        req_src1[63:32] = 32'hFFFF_FFFF;
        req_src2[63:32] = 32'hFFFF_FFFF;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap_c0 ready=%b exp 10", req_ready);
        end
        tick();
        req_src1[63:32] = 32'h0001_0000;
        req_src2[63:32] = 32'h0001_0000;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10 || mul_src1 !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_c1 ready=%b src1=%h exp 10/ffffffff", req_ready, mul_src1);
        end
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL wrap_c3 rsp=%b res=%h exp 10/00000001", rsp_valid, rsp_result);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL wrap_c4 rsp=%b res=%h exp 10/00000000", rsp_valid, rsp_result);
        end
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_grant [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exp_prod  [6] = '{32'd1, 32'd4, 32'd3, 32'd8, 32'd5, 32'd12};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                req_valid = 2'b11;
                req_src1[31:0]  = 32'd1;
                req_src1[63:32] = 32'd2;
                req_src2[31:0]  = 32'(c + 1);
                req_src2[63:32] = 32'(c + 1);
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (c < 6) begin
                vectors++;
                if (req_ready !== exp_grant[c]) begin
                    miscompares++;
                    $display("FAIL fair_grant c%0d got=%b exp=%b", c, req_ready, exp_grant[c]);
                end
            end
            if (c >= 3) begin
                vectors++;
                if (rsp_valid !== exp_grant[c-3] || rsp_result !== exp_prod[c-3]) begin
                    miscompares++;
                    $display("FAIL fair_rsp c%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_result,
                             exp_grant[c-3], exp_prod[c-3]);
                end
            end
            tick();
        end
    endtask

    task automatic test_ptr_hold();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                req_valid = 2'b10;
                req_src1[63:32] = 32'h100 + 32'(c);
                req_src2[63:32] = 32'd2;
            end else if (c < 5) begin
                req_valid = 2'b00;
                req_src1[63:32] = 32'hDEAD_BEEF;
                req_src2[63:32] = 32'hCAFE_F00D;
            end else begin
                req_valid = 2'b11;
            end
            @(negedge clk);
            if (c < 3) begin
                vectors++;
                if (req_ready !== 2'b10) begin
                    miscompares++;
                    $display("FAIL hold_grant c%0d got=%b exp=10", c, req_ready);
                end
            end
            if (c == 3 || c == 4) begin
                vectors++;
                if (mul_src1 !== 32'h102 || mul_src2 !== 32'd2) begin
                    miscompares++;
                    $display("FAIL hold_mulsrc c%0d got=%h,%h exp=102,2", c, mul_src1, mul_src2);
                end
            end
            if (c == 3) begin
                vectors++;
                if (rsp_valid !== 2'b10 || rsp_result !== 32'h200) begin
                    miscompares++;
                    $display("FAIL hold_rsp got=%b/%h exp=10/200", rsp_valid, rsp_result);
                end
            end
            if (c == 5) begin
                vectors++;
                if (req_ready !== 2'b01) begin
                    miscompares++;
                    $display("FAIL hold_next got=%b exp=01", req_ready);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b01;
        req_src1[31:0] = 32'd5;
        req_src2[31:0] = 32'd6;
        tick();
        req_valid = 2'b10;
        req_src1[63:32] = 32'd7;
        req_src2[63:32] = 32'd8;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_c1 ready=%b exp=10", req_ready);
        end
        tick();
        reset = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_c2 ready=%b exp=00", req_ready);
        end
        tick();
        reset = 1'b0;
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00 || rsp_result !== 32'h0 || mul_src1 !== 32'h0 ||
            mul_src2 !== 32'h0 || busy !== 1'b0 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_c3 rsp=%b res=%h src=%h,%h busy=%b ready=%b exp all 0",
                     rsp_valid, rsp_result, mul_src1, mul_src2, busy, req_ready);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_c4 rsp=%b busy=%b exp 00/0", rsp_valid, busy);
        end
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_first_grant got=%b exp=01", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle c%0d ready=%b rsp=%b busy=%b exp 00/00/0", c, req_ready, rsp_valid, busy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_ptr_hold();
        test_reset_midflight();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
